// File: rtl/xlr8_io_pkg.sv
// xlr8_io_pkg: shared pin-reader types and clock constant for the XLR8 fabric.
package xlr8_io_pkg;
   localparam int CLOCK_HZ = 16_000_000;
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
endpackage

// File: rtl/xlr8_button_reader_if.sv
// xlr8_button_reader_if: raw pin in, debounced level/pulses/count out.
interface xlr8_button_reader_if #(parameter int CNT_W = 8);
   logic PIN;
   logic level;
   logic press;
   logic release_pulse;
   logic long_press;
   logic [CNT_W-1:0] press_count;
   modport master (input PIN, output level, press, release_pulse, long_press, press_count);
   modport slave (output PIN, input level, press, release_pulse, long_press, press_count);
endinterface

// File: rtl/xlr8_sync_2ff.sv
// xlr8_sync_2ff: generic two-flop synchronizer with a configurable reset value.
module xlr8_sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge CLOCK)
      if (RESET) {q, meta} <= {RST_VAL, RST_VAL};
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/xlr8_button_reader.sv
// xlr8_button_reader: debounced pushbutton reader with press/release pulses and a wrapping press counter.
// Long-press detection is built only when XLR8_BTN_LONG_PRESS_EN is defined.
module xlr8_button_reader
   import xlr8_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = CLOCK_HZ / 1000,
   parameter int LONG_CYCLES = CLOCK_HZ / 2,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int CNT_W = 8
) (
   input logic CLOCK,
   input logic RESET,
   xlr8_button_reader_if.master bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
      $error("xlr8_button_reader: need DEBOUNCE_CYCLES >= 1 and LONG_CYCLES > DEBOUNCE_CYCLES");
   end
   btn_state_t state, state_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic level_q, level_n, press_q, press_n, rel_q, rel_n;
   logic pin_sync, s;
   // Synchronizer idles at the released pin level so reset never looks like a press.
   xlr8_sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
      .CLOCK(CLOCK), .RESET(RESET), .d(bus.PIN), .q(pin_sync)
   );
   assign s = pin_sync ^ ACTIVE_LOW;
   always_ff @(posedge CLOCK)
      if (RESET) begin
         state   <= IDLE;
         dcnt    <= '0;
         cnt     <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state   <= state_n;
         dcnt    <= dcnt_n;
         cnt     <= cnt_n;
         level_q <= level_n;
         press_q <= press_n;
         rel_q   <= rel_n;
      end
   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      cnt_n   = cnt;
      level_n = level_q;
      press_n = 1'b0;
      rel_n   = 1'b0;
      unique case (state)
         IDLE: if (s) begin state_n = PRESS_WAIT; dcnt_n = '0; end
         PRESS_WAIT:
            if (!s) begin
               state_n = IDLE;
               dcnt_n  = '0;
            end else if (dcnt == D_LAST) begin
               state_n = PRESSED;
               dcnt_n  = '0;
               press_n = 1'b1;
               level_n = 1'b1;
               cnt_n   = cnt + 1'b1;
            end else dcnt_n = dcnt + 1'b1;
         PRESSED: if (!s) begin state_n = RELEASE_WAIT; dcnt_n = '0; end
         RELEASE_WAIT:
            if (s) begin
               state_n = PRESSED;
               dcnt_n  = '0;
            end else if (dcnt == D_LAST) begin
               state_n = IDLE;
               dcnt_n  = '0;
               rel_n   = 1'b1;
               level_n = 1'b0;
            end else dcnt_n = dcnt + 1'b1;
      endcase
   end
   assign bus.level         = level_q;
   assign bus.press         = press_q;
   assign bus.release_pulse = rel_q;
   assign bus.press_count   = cnt;
`ifdef XLR8_BTN_LONG_PRESS_EN
   localparam int HW = $clog2(LONG_CYCLES);
   localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
   logic [HW-1:0] hcnt;
   logic fired, long_q, holding;
   assign holding = state inside {PRESSED, RELEASE_WAIT};
   // Hold count survives release bounces; only an accepted press re-arms it.
   always_ff @(posedge CLOCK) begin
      long_q <= 1'b0;
      if (RESET || press_n) begin
         hcnt  <= '0;
         fired <= 1'b0;
      end else if (holding) begin
         if (hcnt != H_LAST) hcnt <= hcnt + 1'b1;
         else if (!fired) begin
            long_q <= 1'b1;
            fired  <= 1'b1;
         end
      end
   end
   assign bus.long_press = long_q;
`else
   assign bus.long_press = 1'b0;
`endif
endmodule

// File: tb/tb_xlr8_button_reader.sv
// tb_xlr8_button_reader: directed checks of debounce, pulses, count wrap, reset and long press.
module tb_xlr8_button_reader;
   localparam int D = 4;
   localparam int L = 20;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int checks = 0;
   int fails = 0;
   int n_press, n_rel, n_long, press_at, rel_at, long_at, overlap;
   logic lvl_p, lvl_r;
   logic [7:0] cnt_p;
   xlr8_button_reader_if #(.CNT_W(8)) bus ();
   xlr8_button_reader_if #(.CNT_W(2)) bus_w ();
   xlr8_button_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1), .CNT_W(8)) dut (
      .CLOCK(clk), .RESET(rst), .bus(bus.master)
   );
   xlr8_button_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1), .CNT_W(2)) dut_w (
      .CLOCK(clk), .RESET(rst), .bus(bus_w.master)
   );
   assign bus_w.PIN = bus.PIN;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bus.press) begin
         n_press++;
         press_at = cyc;
         lvl_p = bus.level;
         cnt_p = bus.press_count;
      end
      if (bus.release_pulse) begin
         n_rel++;
         rel_at = cyc;
         lvl_r = bus.level;
      end
      if (bus.long_press) begin
         n_long++;
         long_at = cyc;
      end
      if ((bus.press && bus.release_pulse) || (bus.press && bus.long_press)) overlap++;
   end
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask
   task automatic clr();
      n_press = 0;
      n_rel = 0;
      n_long = 0;
      press_at = -1;
      rel_at = -1;
      long_at = -1;
   endtask
   task automatic test_reset();
      logic [11:0] obs;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.PIN = i[0];
         tick(1);
         obs = {bus.level, bus.press, bus.release_pulse, bus.long_press, bus.press_count};
         checks++;
         if (obs !== 12'h0) begin
            fails++;
            $display("FAIL reset_hold[%0d]: got %h expected 000", i, obs);
         end
      end
      bus.PIN = 1'b1;
      rst = 1'b0;
      tick(3);
      obs = {bus.level, bus.press, bus.release_pulse, bus.long_press, bus.press_count};
      checks++;
      if (obs !== 12'h0) begin
         fails++;
         $display("FAIL reset_exit: got %h expected 000", obs);
      end
   endtask
   task automatic test_glitch();
      clr();
      bus.PIN = 1'b0;
      tick(3);
      bus.PIN = 1'b1;
      tick(12);
      checks++;
      if (n_press !== 0 || bus.level !== 1'b0 || bus.press_count !== 8'd0) begin
         fails++;
         $display("FAIL glitch: presses=%0d level=%b count=%0d expected 0 0 0", n_press, bus.level, bus.press_count);
      end
   endtask
   task automatic test_clean_press();
      int t0;
      clr();
      bus.PIN = 1'b0;
      t0 = cyc + 1;
      tick(15);
      checks++;
      if (n_press !== 1 || press_at !== t0 + 6) begin
         fails++;
         $display("FAIL press_timing: n=%0d at=%0d expected 1 at %0d", n_press, press_at, t0 + 6);
      end
      checks++;
      if (lvl_p !== 1'b1 || cnt_p !== 8'd1 || bus.level !== 1'b1) begin
         fails++;
         $display("FAIL press_state: level=%b count=%0d expected 1 1", lvl_p, cnt_p);
      end
      bus.PIN = 1'b1;
      t0 = cyc + 1;
      tick(15);
      checks++;
      if (n_rel !== 1 || rel_at !== t0 + 6 || lvl_r !== 1'b0) begin
         fails++;
         $display("FAIL release: n=%0d at=%0d level=%b expected 1 at %0d level 0", n_rel, rel_at, lvl_r, t0 + 6);
      end
      checks++;
      if (n_press !== 1 || bus.press_count !== 8'd1) begin
         fails++;
         $display("FAIL press_count_after_release: n=%0d count=%0d expected 1 1", n_press, bus.press_count);
      end
   endtask
   task automatic test_bounce();
      clr();
      for (int i = 0; i < 3; i++) begin
         bus.PIN = 1'b0;
         tick(2);
         bus.PIN = 1'b1;
         tick(2);
      end
      bus.PIN = 1'b0;
      tick(20);
      checks++;
      if (n_press !== 1 || bus.press_count !== 8'd2) begin
         fails++;
         $display("FAIL bounce_press: n=%0d count=%0d expected 1 2", n_press, bus.press_count);
      end
      for (int i = 0; i < 3; i++) begin
         bus.PIN = 1'b1;
         tick(2);
         bus.PIN = 1'b0;
         tick(2);
      end
      bus.PIN = 1'b1;
      tick(20);
      checks++;
      if (n_rel !== 1 || n_press !== 1 || bus.level !== 1'b0) begin
         fails++;
         $display("FAIL bounce_release: rel=%0d press=%0d level=%b expected 1 1 0", n_rel, n_press, bus.level);
      end
   endtask
   task automatic test_long_press();
      clr();
      bus.PIN = 1'b0;
      tick(16);
      bus.PIN = 1'b1;
      tick(2);
      bus.PIN = 1'b0;
      tick(22);
      bus.PIN = 1'b1;
      tick(20);
      checks++;
      if (n_press !== 1 || n_rel !== 1) begin
         fails++;
         $display("FAIL long_hold_edges: press=%0d rel=%0d expected 1 1", n_press, n_rel);
      end
`ifdef XLR8_BTN_LONG_PRESS_EN
      checks++;
      if (n_long !== 1 || long_at !== press_at + L) begin
         fails++;
         $display("FAIL long_press: n=%0d at=%0d expected 1 at %0d", n_long, long_at, press_at + L);
      end
`else
      checks++;
      if (n_long !== 0) begin
         fails++;
         $display("FAIL long_press_disabled: n=%0d expected 0", n_long);
      end
`endif
   endtask
   task automatic test_wrap();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      clr();
      for (int i = 0; i < 5; i++) begin
         bus.PIN = 1'b0;
         tick(10);
         bus.PIN = 1'b1;
         tick(10);
      end
      checks++;
      if (bus_w.press_count !== 2'd1) begin
         fails++;
         $display("FAIL wrap_count: got %0d expected 1", bus_w.press_count);
      end
      checks++;
      if (bus.press_count !== 8'd5 || n_press !== 5 || n_rel !== 5) begin
         fails++;
         $display("FAIL wrap_wide: count=%0d press=%0d rel=%0d expected 5 5 5", bus.press_count, n_press, n_rel);
      end
   endtask
   task automatic test_reset_mid();
      logic [11:0] obs;
      clr();
      bus.PIN = 1'b0;
      tick(10);
      checks++;
      if (bus.level !== 1'b1 || bus.press_count !== 8'd6) begin
         fails++;
         $display("FAIL mid_pressed: level=%b count=%0d expected 1 6", bus.level, bus.press_count);
      end
      rst = 1'b1;
      tick(1);
      obs = {bus.level, bus.press, bus.release_pulse, bus.long_press, bus.press_count};
      checks++;
      if (obs !== 12'h0 || bus_w.press_count !== 2'd0) begin
         fails++;
         $display("FAIL mid_reset: got %h/%0d expected 000/0", obs, bus_w.press_count);
      end
      tick(2);
      bus.PIN = 1'b1;
      rst = 1'b0;
      tick(10);
      bus.PIN = 1'b0;
      tick(10);
      checks++;
      if (n_rel !== 0 || n_press !== 2 || cnt_p !== 8'd1 || bus.press_count !== 8'd1) begin
         fails++;
         $display("FAIL after_reset: rel=%0d press=%0d count=%0d expected 0 2 1", n_rel, n_press, bus.press_count);
      end
      bus.PIN = 1'b1;
      tick(10);
   endtask
   initial begin
      bus.PIN = 1'b1;
      clr();
      overlap = 0;
      test_reset();
      test_glitch();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_wrap();
      test_reset_mid();
      checks++;
      if (overlap !== 0) begin
         fails++;
         $display("FAIL pulse_overlap: got %0d expected 0", overlap);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
